pong_frame_parser: RTL

Receive-side parser for the pong game-state telemetry stream. It sits directly downstream of the byte-level UART receiver on the display/host board. It consumes the 9-byte frame the game transmits: 0xAA, score_left, score_right, pos_left, pos_right, ball_x, ball_y, ball_radius, 0x55. It validates each frame and presents the decoded game state as registered outputs that update atomically once per good frame.

---
 rtl/pong_frame_parser.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pong_frame_parser.sv
// Receive-side parser for the 9-byte pong telemetry frame (AA, 7 payload bytes, 55).
// Validates each frame and commits the decoded game state atomically on a good footer.
//
// state  | meaning
// HUNT   | waiting for 0xAA header, in_frame=0
// FIELD  | collecting payload bytes idx 0..6 into shadow registers
// FOOTER | expecting 0x55 to commit the shadow registers
module pong_frame_parser #(
  parameter int TIMEOUT_CYCLES = 25_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [3:0] pos_left,
  output logic [3:0] pos_right,
  output logic [5:0] ball_x,
  output logic [5:0] ball_y,
  output logic [3:0] ball_radius,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       in_frame,
  output logic [7:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {HUNT, FIELD, FOOTER} state_t;

  state_t        state, state_nx;
  logic [2:0]    idx, idx_nx;
  logic [TW-1:0] tmo_rem, tmo_rem_nx;
  logic          shadow_we;
  logic          commit;
  logic          err;
  logic          field_ok;

  logic [3:0] sh_sl, sh_sr, sh_pl, sh_pr, sh_br;
  logic [5:0] sh_bx, sh_by;

  // Ball coordinates (idx 4,5) are 6-bit; every other payload field is 4-bit.
  assign field_ok = (idx == 3'd4 || idx == 3'd5) ? (rx_data[7:6] == 2'b00)
                                                 : (rx_data[7:4] == 4'h0);

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    tmo_rem_nx = tmo_rem;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    err        = 1'b0;
    case (state)
      HUNT: begin
        if (rx_valid && !rx_error && rx_data == 8'hAA) begin
          state_nx   = FIELD;
          idx_nx     = 3'd0;
          tmo_rem_nx = TMO_LOAD;
        end
      end
      FIELD, FOOTER: begin
        if (rx_error) begin
          err      = 1'b1;
          state_nx = HUNT;
        end else if (rx_valid) begin
          tmo_rem_nx = TMO_LOAD;
          if (state == FIELD && field_ok) begin
            shadow_we = 1'b1;
            if (idx == 3'd6) state_nx = FOOTER;
            else             idx_nx   = idx + 3'd1;
          end else if (state == FOOTER && rx_data == 8'h55) begin
            commit   = 1'b1;
            state_nx = HUNT;
          end else begin
            err = 1'b1;
            // An offending 0xAA is taken as the header of the next frame.
            if (rx_data == 8'hAA) begin
              state_nx = FIELD;
              idx_nx   = 3'd0;
            end else begin
              state_nx = HUNT;
            end
          end
        end else if (tmo_rem == TW'(1)) begin
          err      = 1'b1;
          state_nx = HUNT;
        end else begin
          tmo_rem_nx = tmo_rem - TW'(1);
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT;
      idx      <= 3'd0;
      tmo_rem  <= '0;
      in_frame <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      tmo_rem  <= tmo_rem_nx;
      in_frame <= (state_nx != HUNT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_sl <= 4'h0;
      sh_sr <= 4'h0;
      sh_pl <= 4'h0;
      sh_pr <= 4'h0;
      sh_bx <= 6'h0;
      sh_by <= 6'h0;
      sh_br <= 4'h0;
    end else if (shadow_we) begin
      case (idx)
        3'd0:    sh_sl <= rx_data[3:0];
        3'd1:    sh_sr <= rx_data[3:0];
        3'd2:    sh_pl <= rx_data[3:0];
        3'd3:    sh_pr <= rx_data[3:0];
        3'd4:    sh_bx <= rx_data[5:0];
        3'd5:    sh_by <= rx_data[5:0];
        default: sh_br <= rx_data[3:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_left  <= 4'h0;
      score_right <= 4'h0;
      pos_left    <= 4'h0;
      pos_right   <= 4'h0;
      ball_x      <= 6'h0;
      ball_y      <= 6'h0;
      ball_radius <= 4'h0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= 8'h00;
    end else begin
      frame_valid <= commit;
      frame_err   <= err;
      if (commit) begin
        score_left  <= sh_sl;
        score_right <= sh_sr;
        pos_left    <= sh_pl;
        pos_right   <= sh_pr;
        ball_x      <= sh_bx;
        ball_y      <= sh_by;
        ball_radius <= sh_br;
      end
      if (err && err_count != 8'hFF) err_count <= err_count + 8'h01;
    end
  end

endmodule
